rc4_key_search_ctrl: RTL and testbench
======================================

Name: rc4_key_search_ctrl

Overview:
- Top-level sequencer for the RC4 brute-force cracker.
- Runs three phases per candidate key: S-array init, key scheduling (KSA), then decrypt/PRGA.
- Owns the single S-memory port and muxes it between the three phase engines.
- Judges each decrypted character. On a bad character it aborts the decrypt engine, advances the key and restarts. It stops on success or when the key space is exhausted.

Parameters:
- KEY_W, 24, width of the secret key.
- KEY_FIRST, 24'h000000, first key tried.
- KEY_LAST, 24'h3FFFFF, last key tried (inclusive).
- ABORT_CYC, 2, cycles start_over is held before the decrypt start is dropped.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; search runs while high, sampled in IDLE
- key  out  KEY_W  current candidate key, fed to the KSA engine
- init_start / ksa_start / prga_start  out  1 each  level enables for the phase engines
- init_done / ksa_done / prga_done  in  1 each  level done flags from the engines
- start_over  out  1  abort/restart request to the decrypt engine
- new_char  in  1  decrypt engine has a character ready (held until acknowledged)
- char_data  in  8  decrypted character
- char_compare  out  1  one-cycle acknowledge: character accepted
- init_addr, init_wrdata  in  8 each; init_wren  in  1  S-port request from init
- ksa_addr, ksa_wrdata  in  8 each; ksa_wren  in  1  S-port request from KSA
- prga_addr, prga_wrdata  in  8 each; prga_wren  in  1  S-port request from decrypt
- s_addr, s_wrdata  out  8 each; s_wren  out  1  shared S-memory port
- busy  out  1  high in any state except IDLE/FOUND/FAIL
- found  out  1  key located
- fail  out  1  key space exhausted
- found_key  out  KEY_W  key that passed, valid while found=1

Behaviour:
- All outputs are registered except the S-port mux.
- Reset (synchronous; wins over every other input): state=IDLE, key=KEY_FIRST, all *_start=0, start_over=0, char_compare=0, found=0, fail=0, found_key=0, busy=0.
- Reset mid-search abandons the search immediately; the engines see their start drop on the next edge.
- States:
  - IDLE: start=1 -> INIT, key=KEY_FIRST.
  - INIT: init_start=1. When init_done=1, drop init_start -> KSA.
  - KSA: ksa_start=1. When ksa_done=1, drop ksa_start -> PRGA.
  - PRGA: prga_start=1.
    - A character is valid when char_data is 0x61..0x7A or 0x20.
    - new_char rising (detected against a registered copy) with a valid char: char_compare=1 for exactly one cycle.
    - new_char rising with an invalid char: -> ABORT.
    - prga_done=1 -> FOUND.
  - ABORT: start_over=1 and prga_start=1 for ABORT_CYC cycles, then both 0.
    - key==KEY_LAST -> FAIL.
    - Otherwise key<=key+1 -> INIT.
  - FOUND: found=1, found_key=key, all starts 0. Holds until reset or start=0, which returns to IDLE with flags cleared.
  - FAIL: fail=1, otherwise the same as FOUND.
- Phase change: a done flag is honoured only on its own phase, and the next phase's start rises one cycle after the previous start falls. Stale done levels from an earlier phase are ignored.
- Simultaneous new_char rising and prga_done: prga_done wins -> FOUND.
- start=0 in any busy state -> IDLE; all starts 0; key unchanged.
- S-port mux: INIT selects init_*, KSA selects ksa_*, PRGA/ABORT select prga_*. Every other state drives s_addr=0, s_wrdata=0, s_wren=0. Same-cycle combinational path, no added latency.
- Key arithmetic: unsigned, KEY_W bits; no wrap past KEY_LAST.

Optional Feature:
- Macro KEY_STRIDE2_EN.
- Defined: key advances by 2, so two instances with KEY_FIRST even/odd split the space. FAIL is taken when key+2 > KEY_LAST.
- Undefined: stride 1, as above.

Test Plan:
- Reset sequence: reset=1 for 2 cycles, start=1 -> init_start=1 one cycle after reset releases, key=0, s_* follows init_* inputs.
- Full pass: engine models give init_done, ksa_done, then 32 valid chars 0x61, then prga_done -> 32 char_compare pulses, found=1, found_key=0.
- Bad char: KEY_FIRST=5, char_data=0x07 on new_char -> start_over high 2 cycles with prga_start=1, then key=6, init_start reasserts.
- Exhaustion: KEY_FIRST=KEY_LAST=3, bad char -> fail=1, found=0, key stays 3.
- Tie and stale done: prga_done and a new_char rising with an invalid char in the same cycle -> FOUND, no start_over. A ksa_done held high during PRGA is ignored.
- Mid-run control: reset asserted in KSA -> all outputs at reset values next cycle. Separately, start=0 in PRGA -> IDLE, key unchanged, prga_start=0.

Source files
------------

// File: rtl/rc4_key_search_ctrl.sv
// Top-level RC4 key-search sequencer: init -> KSA -> decrypt per candidate key, with a shared S-memory port.
// Optional macro KEY_STRIDE2_EN: advance the key by 2 so two instances can split the key space.
module rc4_key_search_ctrl #(
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_FIRST = KEY_W'(24'h000000),
  parameter logic [KEY_W-1:0] KEY_LAST  = KEY_W'(24'h3FFFFF),
  parameter int               ABORT_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [KEY_W-1:0] key,
  output logic             init_start,
  output logic             ksa_start,
  output logic             prga_start,
  input  logic             init_done,
  input  logic             ksa_done,
  input  logic             prga_done,
  output logic             start_over,
  input  logic             new_char,
  input  logic [7:0]       char_data,
  output logic             char_compare,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       init_wrdata,
  input  logic             init_wren,
  input  logic [7:0]       ksa_addr,
  input  logic [7:0]       ksa_wrdata,
  input  logic             ksa_wren,
  input  logic [7:0]       prga_addr,
  input  logic [7:0]       prga_wrdata,
  input  logic             prga_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_wrdata,
  output logic             s_wren,
  output logic             busy,
  output logic             found,
  output logic             fail,
  output logic [KEY_W-1:0] found_key
);

`ifdef KEY_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  localparam int CNT_W = $clog2(ABORT_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_KSA, ST_PRGA, ST_ABORT, ST_FOUND, ST_FAIL
  } state_t;

  state_t             state_reg, state_next;
  logic [KEY_W-1:0]   key_reg, key_next;
  logic [CNT_W-1:0]   abort_cnt_reg, abort_cnt_next;
  logic               new_char_q_reg;
  logic               init_start_reg, init_start_next;
  logic               ksa_start_reg, ksa_start_next;
  logic               prga_start_reg, prga_start_next;
  logic               start_over_reg, start_over_next;
  logic               char_compare_reg, char_compare_next;
  logic               busy_reg, busy_next;
  logic               found_reg, found_next;
  logic               fail_reg, fail_next;
  logic [KEY_W-1:0]   found_key_reg, found_key_next;

  logic               char_rise;
  logic               char_ok;
  logic               key_is_last;
  logic [KEY_W-1:0]   key_adv;

  assign char_rise   = new_char && !new_char_q_reg;
  assign char_ok     = ((char_data >= 8'h61) && (char_data <= 8'h7A)) || (char_data == 8'h20);
  // Widened compare so the final step never wraps past KEY_LAST.
  assign key_is_last = ({1'b0, key_reg} + (KEY_W + 1)'(STRIDE)) > {1'b0, KEY_LAST};
  assign key_adv     = key_reg + KEY_W'(STRIDE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      key_reg          <= KEY_FIRST;
      abort_cnt_reg    <= '0;
      new_char_q_reg   <= 1'b0;
      init_start_reg   <= 1'b0;
      ksa_start_reg    <= 1'b0;
      prga_start_reg   <= 1'b0;
      start_over_reg   <= 1'b0;
      char_compare_reg <= 1'b0;
      busy_reg         <= 1'b0;
      found_reg        <= 1'b0;
      fail_reg         <= 1'b0;
      found_key_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      key_reg          <= key_next;
      abort_cnt_reg    <= abort_cnt_next;
      new_char_q_reg   <= new_char;
      init_start_reg   <= init_start_next;
      ksa_start_reg    <= ksa_start_next;
      prga_start_reg   <= prga_start_next;
      start_over_reg   <= start_over_next;
      char_compare_reg <= char_compare_next;
      busy_reg         <= busy_next;
      found_reg        <= found_next;
      fail_reg         <= fail_next;
      found_key_reg    <= found_key_next;
    end
  end

  // Done flags only count once this phase's start is actually up, so stale levels are ignored.
  always_comb begin
    state_next     = state_reg;
    key_next       = key_reg;
    abort_cnt_next = abort_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_INIT;
          key_next   = KEY_FIRST;
        end
      end
      ST_INIT: begin
        if (!start)                          state_next = ST_IDLE;
        else if (init_start_reg && init_done) state_next = ST_KSA;
      end
      ST_KSA: begin
        if (!start)                         state_next = ST_IDLE;
        else if (ksa_start_reg && ksa_done) state_next = ST_PRGA;
      end
      ST_PRGA: begin
        if (!start) begin
          state_next = ST_IDLE;
        end else if (prga_start_reg && prga_done) begin
          state_next = ST_FOUND;
        end else if (prga_start_reg && char_rise && !char_ok) begin
          state_next     = ST_ABORT;
          abort_cnt_next = '0;
        end
      end
      ST_ABORT: begin
        if (!start) begin
          state_next = ST_IDLE;
        end else if (abort_cnt_reg == CNT_W'(ABORT_CYC - 1)) begin
          if (key_is_last) begin
            state_next = ST_FAIL;
          end else begin
            state_next = ST_INIT;
            key_next   = key_adv;
          end
        end else begin
          abort_cnt_next = abort_cnt_reg + 1'b1;
        end
      end
      ST_FOUND, ST_FAIL: begin
        if (!start) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A phase start rises only after a full cycle in the new state, leaving a one-cycle gap between phases.
  always_comb begin
    init_start_next   = (state_next == ST_INIT) &&
                        ((state_reg == ST_INIT) || (state_reg == ST_IDLE));
    ksa_start_next    = (state_next == ST_KSA) && (state_reg == ST_KSA);
    prga_start_next   = ((state_next == ST_PRGA) && (state_reg == ST_PRGA)) ||
                        (state_next == ST_ABORT);
    start_over_next   = (state_next == ST_ABORT);
    char_compare_next = (state_reg == ST_PRGA) && (state_next == ST_PRGA) &&
                        prga_start_reg && char_rise && char_ok;
    busy_next         = (state_next == ST_INIT) || (state_next == ST_KSA) ||
                        (state_next == ST_PRGA) || (state_next == ST_ABORT);
    found_next        = (state_next == ST_FOUND);
    fail_next         = (state_next == ST_FAIL);
    found_key_next    = (state_next == ST_FOUND) ? key_reg : '0;
  end

  always_comb begin
    s_addr   = 8'h00;
    s_wrdata = 8'h00;
    s_wren   = 1'b0;
    case (state_reg)
      ST_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      ST_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      ST_PRGA, ST_ABORT: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

  assign key          = key_reg;
  assign init_start   = init_start_reg;
  assign ksa_start    = ksa_start_reg;
  assign prga_start   = prga_start_reg;
  assign start_over   = start_over_reg;
  assign char_compare = char_compare_reg;
  assign busy         = busy_reg;
  assign found        = found_reg;
  assign fail         = fail_reg;
  assign found_key    = found_key_reg;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: three instances (KEY_FIRST 0, 5, and 3 with KEY_LAST 3) share one stimulus.
module tb_rc4_key_search_ctrl;
  localparam int N = 3;
  localparam int KW = 24;
  localparam int ABORT_CYC = 2;
  localparam int P_IDLE = 0, P_INIT = 1, P_KSA = 2, P_PRGA = 3, P_ABORT = 4, P_FOUND = 5, P_FAIL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0;
  logic init_done = 1'b0, ksa_done = 1'b0, prga_done = 1'b0, new_char = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic [7:0] init_addr = 8'h00, init_wrdata = 8'h00, ksa_addr = 8'h00, ksa_wrdata = 8'h00;
  logic [7:0] prga_addr = 8'h00, prga_wrdata = 8'h00;
  logic init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;

  logic [KW-1:0] key_o [N];
  logic [KW-1:0] found_key_o [N];
  logic init_start_o [N], ksa_start_o [N], prga_start_o [N], start_over_o [N];
  logic char_compare_o [N], busy_o [N], found_o [N], fail_o [N], s_wren_o [N];
  logic [7:0] s_addr_o [N], s_wrdata_o [N];

  function automatic logic [KW-1:0] first_of(input int i);
    return (i == 0) ? 24'd0 : (i == 1) ? 24'd5 : 24'd3;
  endfunction
  function automatic logic [KW-1:0] last_of(input int i);
    return (i == 2) ? 24'd3 : 24'h3FFFFF;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam logic [KW-1:0] FIRST = (gi == 0) ? 24'd0 : (gi == 1) ? 24'd5 : 24'd3;
    localparam logic [KW-1:0] LAST  = (gi == 2) ? 24'd3 : 24'h3FFFFF;
    rc4_key_search_ctrl #(.KEY_W(KW), .KEY_FIRST(FIRST), .KEY_LAST(LAST), .ABORT_CYC(ABORT_CYC)) dut (
      .clk(clk), .reset(reset), .start(start), .key(key_o[gi]),
      .init_start(init_start_o[gi]), .ksa_start(ksa_start_o[gi]), .prga_start(prga_start_o[gi]),
      .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
      .start_over(start_over_o[gi]), .new_char(new_char), .char_data(char_data),
      .char_compare(char_compare_o[gi]),
      .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
      .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
      .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
      .s_addr(s_addr_o[gi]), .s_wrdata(s_wrdata_o[gi]), .s_wren(s_wren_o[gi]),
      .busy(busy_o[gi]), .found(found_o[gi]), .fail(fail_o[gi]), .found_key(found_key_o[gi])
    );
  end

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Behavioural model: phase, whether the phase engine is enabled, key and abort countdown.
  int       m_ph   [N];
  bit       m_en   [N];
  logic [KW-1:0] m_key [N];
  int       m_left [N];
  bit       m_cc   [N];
  bit       m_nc_prev = 1'b0;

  function automatic bit char_ok(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
  endfunction

  always @(posedge clk) begin
    logic rise;
    rise = new_char && !m_nc_prev;
    for (int i = 0; i < N; i++) begin
      int ph, left;
      bit en, cc;
      logic [KW-1:0] k;
      ph = m_ph[i]; en = m_en[i]; k = m_key[i]; left = m_left[i]; cc = 1'b0;
      if (reset) begin
        ph = P_IDLE; en = 1'b0; k = first_of(i); left = 0;
      end else if (ph == P_IDLE) begin
        if (start) begin ph = P_INIT; en = 1'b1; k = first_of(i); end
      end else if (!start) begin
        ph = P_IDLE; en = 1'b0;
      end else begin
        case (ph)
          P_INIT: if (en && init_done) begin ph = P_KSA; en = 1'b0; end else en = 1'b1;
          P_KSA:  if (en && ksa_done) begin ph = P_PRGA; en = 1'b0; end else en = 1'b1;
          P_PRGA: begin
            if (en && prga_done) begin ph = P_FOUND; en = 1'b0; end
            else if (en && rise) begin
              if (char_ok(char_data)) cc = 1'b1;
              else begin ph = P_ABORT; left = ABORT_CYC; end
            end else en = 1'b1;
          end
          P_ABORT: begin
            left = left - 1;
            if (left == 0) begin
              en = 1'b0;
              if (k >= last_of(i)) ph = P_FAIL;
              else begin k = k + 1; ph = P_INIT; end
            end
          end
          default: ;
        endcase
      end
      m_ph[i] <= ph; m_en[i] <= en; m_key[i] <= k; m_left[i] <= left; m_cc[i] <= cc;
    end
    m_nc_prev <= reset ? 1'b0 : new_char;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        logic [72:0] exp_v, got_v;
        logic [7:0] ea, ed;
        logic ew;
        ea = 8'h00; ed = 8'h00; ew = 1'b0;
        if (m_ph[i] == P_INIT) begin ea = init_addr; ed = init_wrdata; ew = init_wren; end
        else if (m_ph[i] == P_KSA) begin ea = ksa_addr; ed = ksa_wrdata; ew = ksa_wren; end
        else if (m_ph[i] == P_PRGA || m_ph[i] == P_ABORT) begin
          ea = prga_addr; ed = prga_wrdata; ew = prga_wren;
        end
        exp_v = {m_key[i],
                 m_ph[i] == P_INIT && m_en[i], m_ph[i] == P_KSA && m_en[i],
                 (m_ph[i] == P_PRGA || m_ph[i] == P_ABORT) && m_en[i], m_ph[i] == P_ABORT,
                 m_cc[i], m_ph[i] >= P_INIT && m_ph[i] <= P_ABORT,
                 m_ph[i] == P_FOUND, m_ph[i] == P_FAIL,
                 (m_ph[i] == P_FOUND) ? m_key[i] : 24'd0, ea, ed, ew};
        got_v = {key_o[i], init_start_o[i], ksa_start_o[i], prga_start_o[i], start_over_o[i],
                 char_compare_o[i], busy_o[i], found_o[i], fail_o[i], found_key_o[i],
                 s_addr_o[i], s_wrdata_o[i], s_wren_o[i]};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL cycle_cmp inst=%0d t=%0t got=%h expected=%h", i, $time, got_v, exp_v);
        end
      end
    end
  end

  int cc_cnt0 = 0, so_cnt1 = 0;
  always @(negedge clk) begin
    if (char_compare_o[0] === 1'b1) cc_cnt0++;
    if (start_over_o[1] === 1'b1) so_cnt1++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
      init_addr = 8'($urandom); init_wrdata = 8'($urandom); init_wren = 1'($urandom);
      ksa_addr = 8'($urandom); ksa_wrdata = 8'($urandom); ksa_wren = 1'($urandom);
      prga_addr = 8'($urandom); prga_wrdata = 8'($urandom); prga_wren = 1'($urandom);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    $display("check %s got=%0h expected=%0h", name, got, exp);
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic sig(input int which, input int i);
    case (which)
      0: return init_start_o[i];
      1: return ksa_start_o[i];
      2: return prga_start_o[i];
      3: return start_over_o[i];
      4: return char_compare_o[i];
      default: return found_o[i];
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int i, input int limit);
    int n;
    n = 0;
    while (sig(which, i) !== 1'b1 && n < limit) begin step(); n++; end
    checks++;
    if (sig(which, i) !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout got=0 expected=1 within %0d cycles", name, limit);
    end
  endtask

  task automatic pulse_done(input int which);
    if (which == 0) init_done = 1'b1; else ksa_done = 1'b1;
    step();
    init_done = 1'b0; ksa_done = 1'b0;
  endtask

  task automatic run_to_prga();
    wait_for("init_start_up", 0, 0, 10);
    pulse_done(0);
    wait_for("ksa_start_up", 1, 0, 10);
    pulse_done(1);
    wait_for("prga_start_up", 2, 0, 10);
  endtask

  initial begin
    int base;
    start = 1'b1;
    step();
    chk_on = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("init_start_after_reset", 32'(init_start_o[0]), 32'd1);
    chk("key_after_reset", 32'(key_o[0]), 32'd0);
    chk("s_addr_follows_init", 32'(s_addr_o[0]), 32'(init_addr));

    // Full pass with 32 good characters; ksa_done stays high through PRGA.
    step(2);
    pulse_done(0);
    wait_for("ksa_start_a", 1, 0, 10);
    ksa_done = 1'b1;
    wait_for("prga_start_a", 2, 0, 10);
    base = cc_cnt0;
    for (int c = 0; c < 32; c++) begin
      char_data = 8'h61; new_char = 1'b1;
      wait_for("char_compare", 4, 0, 5);
      new_char = 1'b0;
      step();
    end
    chk("compare_pulses", 32'(cc_cnt0 - base), 32'd32);
    prga_done = 1'b1;
    wait_for("found_a", 5, 0, 5);
    chk("found_key0", 32'(found_key_o[0]), 32'd0);
    chk("found_key1", 32'(found_key_o[1]), 32'd5);
    chk("found_key2", 32'(found_key_o[2]), 32'd3);
    prga_done = 1'b0; ksa_done = 1'b0;
    start = 1'b0;
    step();
    chk("found_cleared", 32'(found_o[0]), 32'd0);
    start = 1'b1;
    step();

    // Bad character: abort, key advance, exhaustion on the single-key instance.
    run_to_prga();
    base = so_cnt1;
    char_data = 8'h07; new_char = 1'b1;
    wait_for("start_over_b", 3, 1, 4);
    chk("prga_start_in_abort", 32'(prga_start_o[1]), 32'd1);
    step(4);
    new_char = 1'b0;
    chk("start_over_cycles", 32'(so_cnt1 - base), 32'd2);
    chk("key1_advanced", 32'(key_o[1]), 32'd6);
    chk("key0_advanced", 32'(key_o[0]), 32'd1);
    chk("fail2", 32'(fail_o[2]), 32'd1);
    chk("found2_low", 32'(found_o[2]), 32'd0);
    chk("key2_stays", 32'(key_o[2]), 32'd3);

    // prga_done together with a bad character: found wins.
    run_to_prga();
    base = so_cnt1;
    prga_done = 1'b1; char_data = 8'h07; new_char = 1'b1;
    step();
    chk("tie_found1", 32'(found_o[1]), 32'd1);
    chk("tie_found_key1", 32'(found_key_o[1]), 32'd6);
    chk("tie_found_key0", 32'(found_key_o[0]), 32'd1);
    step(2);
    chk("tie_no_start_over", 32'(so_cnt1 - base), 32'd0);
    prga_done = 1'b0; new_char = 1'b0;

    // Reset while in KSA.
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    wait_for("init_start_d", 0, 0, 10);
    pulse_done(0);
    wait_for("ksa_start_d", 1, 0, 10);
    reset = 1'b1;
    step();
    chk("reset_busy", 32'(busy_o[0]), 32'd0);
    chk("reset_ksa_start", 32'(ksa_start_o[0]), 32'd0);
    chk("reset_key1", 32'(key_o[1]), 32'd5);
    reset = 1'b0;
    step();

    // Advance the key once, then drop start in PRGA.
    run_to_prga();
    char_data = 8'h07; new_char = 1'b1;
    step();
    new_char = 1'b0;
    wait_for("init_start_e", 0, 0, 10);
    run_to_prga();
    start = 1'b0;
    step();
    chk("stop_prga_start", 32'(prga_start_o[0]), 32'd0);
    chk("stop_busy", 32'(busy_o[0]), 32'd0);
    chk("stop_key0", 32'(key_o[0]), 32'd1);
    chk("stop_key1", 32'(key_o[1]), 32'd6);
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
